// File: rtl/song_pkg.sv
// Shared types and lookup tables for the song sequencer: ROM word layout,
// FSM state encoding, note-to-half-period and note-to-7-segment tables.
package song_pkg;

  localparam int unsigned NOTE_W = 4;
  localparam int unsigned DUR_W  = 8;
  localparam int unsigned ROM_W  = NOTE_W + DUR_W;
  localparam int unsigned HP_W   = 16;
  localparam int unsigned SEG_W  = 7;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'h0;
  localparam logic [NOTE_W-1:0] NOTE_END  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_PLAY,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_word_t;

  // Rounded half-period in clk cycles for a tone of freq_hz.
  function automatic int unsigned half_per_of(input int unsigned ticks_per_ms,
                                              input int unsigned freq_hz);
    return (ticks_per_ms * 500 + freq_hz / 2) / freq_hz;
  endfunction

  // Equal-tempered C4..B4 plus C5/D5; each branch folds to a constant.
  function automatic logic [HP_W-1:0] note_half_per(input logic [NOTE_W-1:0] note,
                                                    input int unsigned ticks_per_ms);
    case (note)
      4'd1:    return HP_W'(half_per_of(ticks_per_ms, 262));
      4'd2:    return HP_W'(half_per_of(ticks_per_ms, 277));
      4'd3:    return HP_W'(half_per_of(ticks_per_ms, 294));
      4'd4:    return HP_W'(half_per_of(ticks_per_ms, 311));
      4'd5:    return HP_W'(half_per_of(ticks_per_ms, 330));
      4'd6:    return HP_W'(half_per_of(ticks_per_ms, 349));
      4'd7:    return HP_W'(half_per_of(ticks_per_ms, 370));
      4'd8:    return HP_W'(half_per_of(ticks_per_ms, 392));
      4'd9:    return HP_W'(half_per_of(ticks_per_ms, 415));
      4'd10:   return HP_W'(half_per_of(ticks_per_ms, 440));
      4'd11:   return HP_W'(half_per_of(ticks_per_ms, 466));
      4'd12:   return HP_W'(half_per_of(ticks_per_ms, 494));
      4'd13:   return HP_W'(half_per_of(ticks_per_ms, 523));
      4'd14:   return HP_W'(half_per_of(ticks_per_ms, 587));
      default: return '0;
    endcase
  endfunction

  // Segments {g,f,e,d,c,b,a}; sharps show their base letter.
  function automatic logic [SEG_W-1:0] note_seg(input logic [NOTE_W-1:0] note);
    case (note)
      4'd0:               return 7'h40;
      4'd1, 4'd2, 4'd13:  return 7'h39;
      4'd3, 4'd4, 4'd14:  return 7'h5E;
      4'd5:               return 7'h79;
      4'd6, 4'd7:         return 7'h71;
      4'd8, 4'd9:         return 7'h3D;
      4'd10, 4'd11:       return 7'h77;
      4'd12:              return 7'h7C;
      default:            return '0;
    endcase
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick: registered 1-cycle pulse while the counter sits at its
// terminal count; clr holds the counter at zero.
module ms_tick_gen #(
  parameter int unsigned TICKS_PER_MS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICKS_PER_MS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_MS - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICKS_PER_MS - 2);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      tick <= (cnt == CNT_PRE);
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Walks a song ROM entry by entry, holding each note for its duration and
// inserting a silent gap, driving the tone generator and the note display.
module song_sequencer
  import song_pkg::*;
#(
  parameter int unsigned TICKS_PER_MS = 10,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned DUR_UNIT_MS  = 16,
  parameter int unsigned GAP_MS       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROM_W-1:0]  rom_data,
  output logic [HP_W-1:0]   tone_half_per,
  output logic              tone_en,
  output logic [7:0]        led_seg,
  output logic              busy,
  output logic              song_done
);

  localparam int unsigned CNT_W = 16;
  localparam bit HAS_GAP = (GAP_MS != 0);

  state_t            state, state_next;
  rom_word_t         rom_word;
  logic              tick, tick_clr_c;
  logic              play_done_c, gap_done_c;
  logic [CNT_W-1:0]  remaining, remaining_next;
  logic [CNT_W-1:0]  gap_rem, gap_rem_next;
  logic [ADDR_W-1:0] addr_next;
  logic [HP_W-1:0]   hp_next;
  logic [SEG_W-1:0]  seg_next;
  logic              tone_en_next, done_next;

  assign rom_word    = rom_word_t'(rom_data);
  // Tick phase restarts at every fetch, so PLAY sees whole milliseconds.
  assign tick_clr_c  = (state != ST_PLAY) && (state != ST_GAP);
  assign play_done_c = tick && (remaining == CNT_W'(1));
  assign gap_done_c  = tick && (gap_rem == CNT_W'(1));

  ms_tick_gen #(.TICKS_PER_MS(TICKS_PER_MS)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr_c),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start) state_next = ST_FETCH;
        ST_FETCH:  state_next = ST_DECODE;
        ST_DECODE: begin
          if (rom_word.note == NOTE_END)  state_next = loop_en ? ST_FETCH : ST_IDLE;
          else if (rom_word.dur == '0)    state_next = ST_FETCH;
          else                            state_next = ST_PLAY;
        end
        ST_PLAY:   if (play_done_c) state_next = HAS_GAP ? ST_GAP : ST_FETCH;
        ST_GAP:    if (gap_done_c) state_next = ST_FETCH;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_next      = rom_addr;
    remaining_next = remaining;
    gap_rem_next   = gap_rem;
    hp_next        = tone_half_per;
    seg_next       = led_seg[SEG_W-1:0];
    tone_en_next   = tone_en;
    done_next      = 1'b0;
    if (!stop) begin
      case (state)
        ST_IDLE: if (start) addr_next = '0;
        ST_DECODE: begin
          if (rom_word.note == NOTE_END) begin
            if (loop_en) addr_next = '0;
            else         done_next = 1'b1;
          end else if (rom_word.dur == '0) begin
            addr_next = rom_addr + ADDR_W'(1);
          end else begin
            remaining_next = CNT_W'(rom_word.dur * DUR_UNIT_MS);
            if (rom_word.note != NOTE_REST)
              hp_next = note_half_per(rom_word.note, TICKS_PER_MS);
            seg_next     = note_seg(rom_word.note);
            tone_en_next = (rom_word.note != NOTE_REST);
          end
        end
        ST_PLAY: begin
          if (tick) remaining_next = remaining - CNT_W'(1);
          if (play_done_c) begin
            tone_en_next = 1'b0;
            addr_next    = rom_addr + ADDR_W'(1);
            gap_rem_next = CNT_W'(GAP_MS);
          end
        end
        ST_GAP: if (tick) gap_rem_next = gap_rem - CNT_W'(1);
        default: ;
      endcase
    end
    // Idle is always dark and silent; the pitch register is left alone.
    if (state_next == ST_IDLE) begin
      tone_en_next = 1'b0;
      seg_next     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr      <= '0;
      remaining     <= '0;
      gap_rem       <= '0;
      tone_half_per <= '0;
      tone_en       <= 1'b0;
      led_seg       <= '0;
      busy          <= 1'b0;
      song_done     <= 1'b0;
    end else begin
      rom_addr      <= addr_next;
      remaining     <= remaining_next;
      gap_rem       <= gap_rem_next;
      tone_half_per <= hp_next;
      tone_en       <= tone_en_next;
      led_seg       <= {state_next != ST_IDLE, seg_next};
      busy          <= (state_next != ST_IDLE);
      song_done     <= done_next;
    end
  end

endmodule
